// File: rtl/sine_wave_renderer_if.sv
// Video timing bus from vga_encoder into the pixel renderer.
// The master side (encoder) drives the raster position and syncs.
// The slave side (renderer) consumes them.
interface sine_wave_renderer_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       at_display_area;

    modport master (output hcount, vcount, hsync, vsync, at_display_area);
    modport slave  (input  hcount, vcount, hsync, vsync, at_display_area);
endinterface

// File: rtl/sine_wave_renderer.sv
// sine_wave_renderer: draws a scrolling sine-wave band into 4:4:4 RGB.
// Three-stage pixel pipeline (index -> sine ROM -> band test).
// The syncs and the display flag travel alongside the pixel, so every output is 3 cycles behind its input.
// The wave phase advances by 'speed' once per frame, at hcount==0 / vcount==V_ACTIVE.
// Optional feature macro: WAVE_FILL_EN. When it is defined, the area below the band is painted with FILL_COLOR.
module sine_wave_renderer #(
    parameter int CENTER_Y  = 240,
    parameter int THICKNESS = 2,
    parameter int V_ACTIVE  = 480
`ifdef WAVE_FILL_EN
    ,
    parameter logic [11:0] FILL_COLOR = 12'h115
`endif
) (
    input  logic                        vga_clock,
    input  logic                        reset,
    sine_wave_renderer_if.slave         vga_in,
    input  logic [3:0]                  speed,
    input  logic [1:0]                  amp_shift,
    input  logic [11:0]                 wave_color,
    output logic [3:0]                  vga_r,
    output logic [3:0]                  vga_g,
    output logic [3:0]                  vga_b,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        frame_tick,
    output logic [7:0]                  phase
);

    localparam logic signed [10:0] CENTER = 11'(CENTER_Y);
    localparam logic signed [10:0] THK    = 11'(THICKNESS);

    // First quarter of round(127*sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry.
    localparam logic [6:0] QUARTER_SINE [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    // Full-period sample derived from the quarter table.
    // Odd quadrants mirror the quarter table; the upper half is negated.
    function automatic logic signed [7:0] sine_entry(input logic [7:0] idx);
        logic [6:0] mag;
        if (idx[6]) begin
            mag = QUARTER_SINE[7'd64 - {1'b0, idx[5:0]}];
        end else begin
            mag = QUARTER_SINE[{1'b0, idx[5:0]}];
        end
        return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic signed [7:0] sine_rom [0:255];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            assign sine_rom[gi] = sine_entry(8'(gi));
        end
    endgenerate

    // Frame phase state
    logic [7:0]  phase_q;
    logic        frame_tick_q;
    logic        boundary_d;

    // Stage 1 registers
    logic [7:0]  idx_q;
    logic [9:0]  vcount_s1_q;
    logic        hsync_s1_q, vsync_s1_q, disp_s1_q;
    logic [1:0]  amp_s1_q;
    logic [11:0] color_s1_q;

    // Stage 2 registers
    logic signed [7:0] sine_q;
    logic [9:0]  vcount_s2_q;
    logic        hsync_s2_q, vsync_s2_q, disp_s2_q;
    logic [1:0]  amp_s2_q;
    logic [11:0] color_s2_q;

    // Stage 3 (output) registers
    logic [11:0] rgb_q;
    logic        hsync_q, vsync_q;

    // Stage 3 combinational terms
    logic signed [10:0] sine_ext_d;
    logic signed [10:0] wave_y_d;
    logic signed [10:0] dist_d;
    logic               in_band_d;
    logic [11:0]        bg_d;
    logic [11:0]        pixel_d;

    assign boundary_d = (vga_in.hcount == 10'd0) && (vga_in.vcount == 10'(V_ACTIVE));

    // Phase advances once per frame; speed only matters on the boundary cycle.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            phase_q      <= 8'd0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= boundary_d;
            if (boundary_d) begin
                phase_q <= phase_q + {4'd0, speed};
            end
        end
    end

    // Stage 1: table index from the column (4-pixel steps) plus phase; carry the rest along.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            idx_q       <= 8'd0;
            vcount_s1_q <= 10'd0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            disp_s1_q   <= 1'b0;
            amp_s1_q    <= 2'd0;
            color_s1_q  <= 12'd0;
        end else begin
            idx_q       <= vga_in.hcount[9:2] + phase_q;
            vcount_s1_q <= vga_in.vcount;
            hsync_s1_q  <= vga_in.hsync;
            vsync_s1_q  <= vga_in.vsync;
            disp_s1_q   <= vga_in.at_display_area;
            amp_s1_q    <= amp_shift;
            color_s1_q  <= wave_color;
        end
    end

    // Stage 2: registered sine ROM read.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            sine_q      <= 8'sd0;
            vcount_s2_q <= 10'd0;
            hsync_s2_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
            disp_s2_q   <= 1'b0;
            amp_s2_q    <= 2'd0;
            color_s2_q  <= 12'd0;
        end else begin
            sine_q      <= sine_rom[idx_q];
            vcount_s2_q <= vcount_s1_q;
            hsync_s2_q  <= hsync_s1_q;
            vsync_s2_q  <= vsync_s1_q;
            disp_s2_q   <= disp_s1_q;
            amp_s2_q    <= amp_s1_q;
            color_s2_q  <= color_s1_q;
        end
    end

    // Wave row for this column, and the signed row distance from it.
    // A positive distance means the pixel lies below the band on screen.
    assign sine_ext_d = {{3{sine_q[7]}}, sine_q};
    assign wave_y_d   = CENTER - (sine_ext_d >>> amp_s2_q);
    assign dist_d     = $signed({1'b0, vcount_s2_q}) - wave_y_d;
    assign in_band_d  = (dist_d >= -THK) && (dist_d <= THK);

`ifdef WAVE_FILL_EN
    assign bg_d = (dist_d > THK) ? FILL_COLOR : 12'h000;
`else
    assign bg_d = 12'h000;
`endif

    assign pixel_d = in_band_d ? color_s2_q : bg_d;

    // Stage 3: blank outside the visible area; the syncs leave in step with the pixel.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            rgb_q   <= 12'd0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            rgb_q   <= disp_s2_q ? pixel_d : 12'h000;
            hsync_q <= hsync_s2_q;
            vsync_q <= vsync_s2_q;
        end
    end

    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign frame_tick = frame_tick_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_sine_wave_renderer.sv
// Scoreboard bench for sine_wave_renderer.
// Each driven cycle pushes an expected pixel and sync word, due 3 cycles later.
// It also pushes an expected frame_tick and phase word, due 1 cycle later.
// Both are popped and compared at the falling edge.
module tb_sine_wave_renderer;

    logic        vga_clock = 1'b0;
    logic        reset;
    logic [3:0]  speed;
    logic [1:0]  amp_shift;
    logic [11:0] wave_color;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, frame_tick;
    logic [7:0]  phase;

    always #20 vga_clock = ~vga_clock;

    sine_wave_renderer_if vif ();

    sine_wave_renderer dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .vga_in     (vif),
        .speed      (speed),
        .amp_shift  (amp_shift),
        .wave_color (wave_color),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick),
        .phase      (phase)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t        pix_q[$];
    exp_t        ctl_q[$];
    logic        rst_hist [0:4095];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  model_phase;
    logic [3:0]  cfg_speed;
    logic [1:0]  cfg_amp;
    logic [11:0] cfg_color;
    bit          push_en;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic int sine_ref(input int idx);
        real a;
        real v;
        a = 2.0 * 3.14159265358979 * real'(idx) / 256.0;
        v = 127.0 * $sin(a);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic logic [11:0] model_pixel(input logic [9:0] h, input logic [9:0] v, input logic disp,
                                                input logic [1:0] amp, input logic [11:0] col,
                                                input logic [7:0] ph);
        int idx;
        int s;
        int y;
        int d;
        idx = (int'(h[9:2]) + int'(ph)) % 256;
        s   = sine_ref(idx);
        y   = 240 - (s >>> amp);
        d   = int'(v) - y;
        if (!disp) return 12'h000;
        if (d >= -2 && d <= 2) return col;
`ifdef WAVE_FILL_EN
        if (d > 2) return 12'h115;
`endif
        return 12'h000;
    endfunction

    task automatic step(input string tag, input logic rst, input logic [9:0] h, input logic [9:0] v,
                        input logic hs, input logic vs, input logic disp);
        exp_t        e;
        logic        boundary;
        int          n;
        logic [15:0] exp_val;
        @(posedge vga_clock);
        cyc++;
        #1;
        reset               = rst;
        vif.hcount          = h;
        vif.vcount          = v;
        vif.hsync           = hs;
        vif.vsync           = vs;
        vif.at_display_area = disp;
        speed               = cfg_speed;
        amp_shift           = cfg_amp;
        wave_color          = cfg_color;
        rst_hist[cyc]       = rst;
        boundary            = (h == 10'd0) && (v == 10'd480);
        if (push_en) begin
            e.due = cyc + 3;
            e.tag = tag;
            e.val = {2'b00, model_pixel(h, v, disp, cfg_amp, cfg_color, model_phase), hs, vs};
            pix_q.push_back(e);
        end
        if (rst) model_phase = 8'd0;
        else if (boundary) model_phase = model_phase + {4'd0, cfg_speed};
        if (push_en) begin
            e.due = cyc + 1;
            e.tag = {tag, "/ctl"};
            e.val = {7'd0, boundary & ~rst, model_phase};
            ctl_q.push_back(e);
        end
        @(negedge vga_clock);
        while (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
            e = ctl_q.pop_front();
            check_value(e.tag, {7'd0, frame_tick, phase}, e.val);
        end
        while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            e = pix_q.pop_front();
            n = e.due - 3;
            exp_val = e.val;
            if (rst_hist[n] | rst_hist[n + 1] | rst_hist[n + 2]) exp_val = 16'h0000;
            check_value(e.tag, {2'b00, vga_r, vga_g, vga_b, hsync_out, vsync_out}, exp_val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; speed = 4'd0; amp_shift = 2'd0; wave_color = 12'd0;
        vif.hcount = 10'd0; vif.vcount = 10'd0; vif.hsync = 1'b0; vif.vsync = 1'b0;
        vif.at_display_area = 1'b0;
        model_phase = 8'd0; cfg_speed = 4'd0; cfg_amp = 2'd0; cfg_color = 12'hF00; push_en = 1'b1;

        // Reset held with arbitrary inputs; the last reset cycle also sits on a frame boundary.
        for (int i = 0; i < 4; i++)
            step("reset", 1'b1, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        cfg_speed = 4'd7;
        step("reset_boundary", 1'b1, 10'd0, 10'd480, 1'b1, 1'b1, 1'b1);

        // Basic drawing, band edges, amplitude scaling, blanking, fill region.
        cfg_speed = 4'd5;
        step("center",      1'b0, 10'd0,   10'd240, 1'b0, 1'b0, 1'b1);
        step("peak",        1'b0, 10'd256, 10'd113, 1'b0, 1'b0, 1'b1);
        step("peak_off",    1'b0, 10'd256, 10'd240, 1'b0, 1'b0, 1'b1);
        step("edge_lo_in",  1'b0, 10'd0,   10'd238, 1'b0, 1'b0, 1'b1);
        step("edge_hi_in",  1'b0, 10'd0,   10'd242, 1'b0, 1'b0, 1'b1);
        step("edge_lo_out", 1'b0, 10'd0,   10'd237, 1'b0, 1'b0, 1'b1);
        step("edge_hi_out", 1'b0, 10'd0,   10'd243, 1'b0, 1'b0, 1'b1);
        step("trough",      1'b0, 10'd768, 10'd367, 1'b0, 1'b0, 1'b1);
        step("fill_below",  1'b0, 10'd0,   10'd300, 1'b0, 1'b0, 1'b1);
        step("fill_above",  1'b0, 10'd0,   10'd100, 1'b0, 1'b0, 1'b1);
        step("blanked",     1'b0, 10'd0,   10'd240, 1'b0, 1'b0, 1'b0);
        cfg_amp = 2'd1;
        step("amp1_peak",   1'b0, 10'd256, 10'd177, 1'b0, 1'b0, 1'b1);
        cfg_amp = 2'd3; cfg_color = 12'h0A5;
        step("amp3_trough", 1'b0, 10'd768, 10'd256, 1'b0, 1'b0, 1'b1);
        step("amp3_out",    1'b0, 10'd768, 10'd253, 1'b0, 1'b0, 1'b1);
        cfg_amp = 2'd0; cfg_color = 12'hF00;

        // Three frame boundaries at speed 5, with a mid-frame speed change in between that must not matter.
        for (int i = 0; i < 3; i++) begin
            step("frame", 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
            cfg_speed = 4'd9;
            step("mid_frame", 1'b0, 10'd40, 10'd240, 1'b0, 1'b0, 1'b1);
            cfg_speed = 4'd5;
        end

        // Walk the phase to 250, then wrap past 255.
        cfg_speed = 4'd15;
        for (int i = 0; i < 15; i++) step("frame15", 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        cfg_speed = 4'd10;
        step("frame_to_250", 1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        step("frame_wrap",   1'b0, 10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        step("phase4_pix",   1'b0, 10'd0, 10'd228, 1'b0, 1'b0, 1'b1);

        // Sync delay and pulse width: a 96-cycle hsync pulse and a 20-cycle vsync pulse.
        for (int i = 0; i < 3; i++) step("hs_pre", 1'b0, 10'(i * 7), 10'd200, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 96; i++) step("hsync", 1'b0, 10'(i * 6), 10'd200, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("hs_post", 1'b0, 10'(700 + i), 10'd200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("vsync", 1'b0, 10'(i * 4), 10'd490, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("vs_post", 1'b0, 10'd0, 10'd500, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame: pixels in flight are flushed and the phase restarts at 0.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b0, 10'd0, 10'd228, 1'b1, 1'b1, 1'b1);
        step("mid_rst", 1'b1, 10'd0, 10'd240, 1'b1, 1'b1, 1'b1);
        step("mid_rst", 1'b1, 10'd0, 10'd240, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step("post_rst", 1'b0, 10'd0, 10'd240, 1'b1, 1'b0, 1'b1);

        // Let the last expectations come out of the pipeline.
        push_en = 1'b0;
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check_value("scoreboard_empty", 16'(pix_q.size() + ctl_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
